// File: rtl/mca_sample_scheduler.sv
// mca_sample_scheduler
// Sequencing controller for the MCA hierarchical-adder FIR datapath.
// Counts incoming control vectors, drives the S-buffer shift enable, fires a
// start pulse into the adder tree every cfg_ratio vectors once the S-buffer
// is full, waits out the adder-tree latency and captures the result into a
// valid/ready output register.
//
// Output handshake: out_sample is offered while out_valid is high and is
// consumed in any cycle where out_valid && out_ready. Once raised, out_valid
// stays high and out_sample stays stable until that consume cycle. The only
// exception is a capture that lands on an unconsumed sample: the capture
// overwrites out_sample and sets the sticky overrun flag. A capture in the
// same cycle as a consume loads the new sample, keeps out_valid high and does
// not count as an overrun.
module mca_sample_scheduler #(
    parameter int K_MAX             = 256,
    parameter int N_MAX             = 8,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int MCA_NUM_ADDITIONS = 16,
    parameter int LATENCY           = 20,
    parameter int RATIO_W           = 10
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 enable,
    input  logic [N_MAX-1:0]                     cfg_N,
    input  logic [K_MAX/MCA_NUM_ADDITIONS-1:0]   cfg_K,
    input  logic [RATIO_W-1:0]                   cfg_ratio,
    input  logic                                 in_valid,
    output logic                                 shift_en,
    output logic [N_MAX-1:0]                     mca_N,
    output logic [K_MAX/MCA_NUM_ADDITIONS-1:0]   mca_K,
    output logic                                 mca_start,
    input  logic [WIDTH_COEFFICIENT-1:0]         mca_sample,
    output logic [WIDTH_COEFFICIENT-1:0]         out_sample,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overrun,
    output logic                                 cfg_err,
    output logic                                 busy,
    output logic [1:0]                           dbg_state
);

    localparam int K_W    = K_MAX / MCA_NUM_ADDITIONS;
    localparam int FILL_W = $clog2(K_MAX) + 1;

    // Fill count value at which the S-buffer holds K_MAX vectors.
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(K_MAX);
    // Value loaded into the latency counter when a start pulse goes out.
    localparam logic [RATIO_W-1:0] LAT_LOAD  = RATIO_W'(LATENCY);
    // Smallest ratio that keeps at most one computation in flight.
    localparam logic [RATIO_W:0]   MIN_RATIO = (RATIO_W+1)'(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                         state_q,      state_d;
    logic [FILL_W-1:0]              fill_cnt_q,   fill_cnt_d;
    logic [RATIO_W-1:0]             dec_cnt_q,    dec_cnt_d;
    logic [RATIO_W-1:0]             lat_cnt_q,    lat_cnt_d;
    logic [RATIO_W-1:0]             ratio_q,      ratio_d;
    logic [N_MAX-1:0]               n_mask_q,     n_mask_d;
    logic [K_W-1:0]                 k_mask_q,     k_mask_d;
    logic                           start_q,      start_d;
    logic [WIDTH_COEFFICIENT-1:0]   out_sample_q, out_sample_d;
    logic                           out_valid_q,  out_valid_d;
    logic                           overrun_q,    overrun_d;
    logic                           cfg_err_q,    cfg_err_d;
    logic                           err_block_q,  err_block_d;
    logic                           busy_q,       busy_d;

    logic cfg_bad;
    logic capture;
    logic consume;
    logic in_stream;

    // A start request is illegal if it could put two computations in flight
    // or if it enables no analog state or no tap group.
    assign cfg_bad = ({1'b0, cfg_ratio} < MIN_RATIO) || (cfg_N == '0) || (cfg_K == '0);

    // The adder-tree result is valid in the cycle the latency counter is 1.
    assign capture = (lat_cnt_q == RATIO_W'(1));
    assign consume = out_valid_q && out_ready;

    // Vectors are accepted only while streaming and enable is still high, so
    // dropping enable stops the shift in that very cycle.
    assign in_stream = in_valid && enable && ((state_q == S_FILL) || (state_q == S_RUN));

    // Next-state, counter and output-register computation.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        ratio_d      = ratio_q;
        n_mask_d     = n_mask_q;
        k_mask_d     = k_mask_q;
        start_d      = 1'b0;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        cfg_err_d    = cfg_err_q;
        err_block_d  = err_block_q;

        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    // A rejected configuration is retried only after enable
                    // has gone low, so a static bad setting cannot spin.
                    err_block_d = 1'b0;
                end else if (!err_block_q) begin
                    ratio_d   = cfg_ratio;
                    n_mask_d  = cfg_N;
                    k_mask_d  = cfg_K;
                    overrun_d = 1'b0;
                    cfg_err_d = cfg_bad;
                    if (cfg_bad) begin
                        err_block_d = 1'b1;
                    end else begin
                        fill_cnt_d = '0;
                        state_d    = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else if (in_valid) begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_LAST - FILL_W'(1)) begin
                        dec_cnt_d = '0;
                        state_d   = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else if (in_valid) begin
                    if (dec_cnt_q == ratio_q - RATIO_W'(1)) begin
                        dec_cnt_d = '0;
                        start_d   = 1'b1;
                    end else begin
                        dec_cnt_d = dec_cnt_q + RATIO_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                // Leave only once no start is pending and the in-flight
                // result, if any, has been captured.
                if (!start_q && (lat_cnt_q == '0)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latency counter runs independently of the state so a start issued
        // on the way into DRAIN is still tracked to completion.
        if (start_q) begin
            lat_cnt_d = LAT_LOAD;
        end else if (lat_cnt_q != '0) begin
            lat_cnt_d = lat_cnt_q - RATIO_W'(1);
        end

        // Output register: capture wins over consume; an overwrite of an
        // unconsumed sample is flagged.
        if (capture) begin
            out_sample_d = mca_sample;
            out_valid_d  = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            dec_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            ratio_q      <= '0;
            n_mask_q     <= '0;
            k_mask_q     <= '0;
            start_q      <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_block_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            ratio_q      <= ratio_d;
            n_mask_q     <= n_mask_d;
            k_mask_q     <= k_mask_d;
            start_q      <= start_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            cfg_err_q    <= cfg_err_d;
            err_block_q  <= err_block_d;
            busy_q       <= busy_d;
        end
    end

    assign shift_en   = in_stream;
    assign mca_N      = n_mask_q;
    assign mca_K      = k_mask_q;
    assign mca_start  = start_q;
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mca_sample_scheduler.sv
// tb_mca_sample_scheduler
// Directed bench for mca_sample_scheduler in the small build
// (LATENCY=4, K_MAX=8, RATIO_W=4, 4-bit K mask).
module tb_mca_sample_scheduler;

    localparam int K_MAX             = 8;
    localparam int N_MAX             = 8;
    localparam int WIDTH_COEFFICIENT = 32;
    localparam int MCA_NUM_ADDITIONS = 2;
    localparam int LATENCY           = 4;
    localparam int RATIO_W           = 4;
    localparam int K_W               = K_MAX / MCA_NUM_ADDITIONS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         resetn;
    logic                         enable;
    logic [N_MAX-1:0]             cfg_N;
    logic [K_W-1:0]               cfg_K;
    logic [RATIO_W-1:0]           cfg_ratio;
    logic                         in_valid;
    logic                         shift_en;
    logic [N_MAX-1:0]             mca_N;
    logic [K_W-1:0]               mca_K;
    logic                         mca_start;
    logic [WIDTH_COEFFICIENT-1:0] mca_sample;
    logic [WIDTH_COEFFICIENT-1:0] out_sample;
    logic                         out_valid;
    logic                         out_ready;
    logic                         overrun;
    logic                         cfg_err;
    logic                         busy;
    logic [1:0]                   dbg_state;

    mca_sample_scheduler #(
        .K_MAX             (K_MAX),
        .N_MAX             (N_MAX),
        .WIDTH_COEFFICIENT (WIDTH_COEFFICIENT),
        .MCA_NUM_ADDITIONS (MCA_NUM_ADDITIONS),
        .LATENCY           (LATENCY),
        .RATIO_W           (RATIO_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .cfg_N      (cfg_N),
        .cfg_K      (cfg_K),
        .cfg_ratio  (cfg_ratio),
        .in_valid   (in_valid),
        .shift_en   (shift_en),
        .mca_N      (mca_N),
        .mca_K      (mca_K),
        .mca_start  (mca_start),
        .mca_sample (mca_sample),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- adder-tree model ----------------
    // Result of launch k (1-based); any other cycle carries a poison value so
    // a capture on the wrong cycle is visible.
    function automatic logic [31:0] result_of(input int k);
        return 32'hF000_0000 - 32'(k * 12345);
    endfunction

    int                 launches = 0;
    logic [LATENCY-1:0] start_pipe = '0;

    always @(posedge clk) begin
        start_pipe <= {start_pipe[LATENCY-2:0], mca_start};
        if (mca_start) launches <= launches + 1;
    end

    assign mca_sample = start_pipe[LATENCY-1] ? result_of(launches) : 32'hBAD0_0BAD;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int  base;
    int  v;
    bit  e;

    initial begin
        resetn    = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cfg_N     = '0;
        cfg_K     = '0;
        cfg_ratio = '0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy",       busy,       0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_mca_start",  mca_start,  0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_overrun",    overrun,    0);
        chk("rst_cfg_err",    cfg_err,    0);
        chk("rst_mca_N",      mca_N,      0);
        chk("rst_mca_K",      mca_K,      0);
        chk("rst_shift_en",   shift_en,   0);
        repeat (2) tick();
        resetn   = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // ---- continuous stream, ratio 5 ----
        base      = launches;
        cfg_N     = 8'hA5;
        cfg_K     = 4'h9;
        cfg_ratio = 4'd5;
        out_ready = 1'b1;
        enable    = 1'b1;
        tick();
        chk("t2_busy",    busy,      1);
        chk("t2_state",   dbg_state, 2'd1);
        chk("t2_mca_N",   mca_N,     8'hA5);
        chk("t2_mca_K",   mca_K,     4'h9);
        chk("t2_cfg_err", cfg_err,   0);
        in_valid = 1'b1;
        #1;
        chk("t2_shift_en", shift_en, 1);
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("t2_first_start", mca_start, 32'(i == 13));
        end
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("t2_second_start", mca_start, 32'(j == 5));
            chk("t2_valid_rise",   out_valid, 32'(j == 5));
        end
        chk("t2_sample1", out_sample, result_of(base + 1));
        tick();
        chk("t2_consumed", out_valid, 0);
        repeat (4) tick();
        chk("t2_valid2",  out_valid,  1);
        chk("t2_sample2", out_sample, result_of(base + 2));
        chk("t2_start3",  mca_start,  1);

        // ---- asynchronous reset mid-RUN ----
        #3 resetn = 1'b0;
        #1;
        chk("t1_busy",       busy,       0);
        chk("t1_mca_start",  mca_start,  0);
        chk("t1_out_valid",  out_valid,  0);
        chk("t1_out_sample", out_sample, 0);
        chk("t1_mca_N",      mca_N,      0);
        chk("t1_mca_K",      mca_K,      0);
        chk("t1_shift_en",   shift_en,   0);
        chk("t1_state",      dbg_state,  0);
        enable   = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_no_start", mca_start, 0);
            chk("t1_idle",     busy,      0);
        end
        chk("t1_no_valid", out_valid, 0);

        // ---- illegal configuration ----
        cfg_N     = 8'h3C;
        cfg_K     = 4'h6;
        cfg_ratio = 4'd4;
        enable    = 1'b1;
        tick();
        chk("t3_err",    cfg_err, 1);
        chk("t3_busy",   busy,    0);
        chk("t3_mca_N",  mca_N,   8'h3C);
        cfg_ratio = 4'd6;
        repeat (2) tick();
        chk("t3_err_held",  cfg_err, 1);
        chk("t3_busy_held", busy,    0);
        enable = 1'b0;
        tick();
        chk("t3_err_low",  cfg_err, 1);
        enable = 1'b1;
        tick();
        chk("t3_err_clr",  cfg_err,   0);
        chk("t3_fill",     busy,      1);
        chk("t3_state",    dbg_state, 2'd1);
        enable = 1'b0;
        tick();
        chk("t3_drain",    dbg_state, 2'd3);
        tick();
        chk("t3_idle",     busy,      0);
        cfg_N  = 8'h00;
        enable = 1'b1;
        tick();
        chk("t3_zero_n_err",  cfg_err, 1);
        chk("t3_zero_n_busy", busy,    0);
        enable = 1'b0;
        tick();

        // ---- overrun and same-cycle capture/consume ----
        base      = launches;
        cfg_N     = 8'h11;
        cfg_K     = 4'h1;
        cfg_ratio = 4'd5;
        out_ready = 1'b0;
        enable    = 1'b1;
        tick();
        chk("t4_err_clr", cfg_err, 0);
        chk("t4_busy",    busy,    1);
        in_valid = 1'b1;
        repeat (13) tick();
        chk("t4_start", mca_start, 1);
        repeat (5) tick();
        chk("t4_valid1",   out_valid,  1);
        chk("t4_sample1",  out_sample, result_of(base + 1));
        chk("t4_no_ovr1",  overrun,    0);
        repeat (4) tick();
        chk("t4_stable",   out_sample, result_of(base + 1));
        chk("t4_held",     out_valid,  1);
        out_ready = 1'b1;
        tick();
        chk("t4_same_valid",  out_valid,  1);
        chk("t4_same_sample", out_sample, result_of(base + 2));
        chk("t4_same_no_ovr", overrun,    0);
        out_ready = 1'b0;
        repeat (5) tick();
        chk("t4_overrun",    overrun,    1);
        chk("t4_ovr_sample", out_sample, result_of(base + 3));
        chk("t4_ovr_valid",  out_valid,  1);
        enable   = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 30 && busy; k++) tick();
        chk("t4_drained",     busy,       0);
        chk("t4_last_sample", out_sample, result_of(base + 4));
        chk("t4_sticky",      overrun,    1);
        out_ready = 1'b1;
        tick();
        chk("t4_consumed", out_valid, 0);

        // ---- alternating in_valid ----
        base      = launches;
        cfg_N     = 8'h5A;
        cfg_K     = 4'hF;
        cfg_ratio = 4'd5;
        enable    = 1'b1;
        tick();
        chk("t5_ovr_clr", overrun, 0);
        chk("t5_busy",    busy,    1);
        v = 0;
        for (int i = 0; i < 45; i++) begin
            e        = (i % 2 == 0);
            in_valid = e;
            #1;
            chk("t5_shift_en", shift_en, 32'(e));
            if (e) v++;
            tick();
            chk("t5_start", mca_start, 32'(e && (v == 13 || v == 18 || v == 23)));
        end

        // ---- enable dropped two clocks after a start ----
        in_valid = 1'b1;
        tick();
        chk("t6_no_restart", mca_start, 0);
        tick();
        enable    = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t6_shift_stop", shift_en, 0);
        tick();
        chk("t6_drain",      dbg_state, 2'd3);
        chk("t6_not_yet3",   out_valid, 0);
        tick();
        chk("t6_not_yet4",   out_valid, 0);
        tick();
        chk("t6_captured",   out_valid,  1);
        chk("t6_sample",     out_sample, result_of(base + 3));
        chk("t6_busy_still", busy,       1);
        tick();
        chk("t6_idle",       busy,      0);
        chk("t6_state",      dbg_state, 2'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_no_start", mca_start, 0);
            chk("t6_no_shift", shift_en,  0);
        end
        chk("t6_kept", out_sample, result_of(base + 3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
